// File: rtl/mutex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mutex_pkg
// Description : Shared types and helpers for the round-robin mutex.
//               Provides the two-state FSM encoding and the function that
//               sizes the owner index.
// Revision    : 1.0 - initial release
// ============================================================================
package mutex_pkg;

  // FSM encoding: the resource is either free or owned by one channel
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Bits needed to index 'value' items (ceil(log2(value)))
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Owner-index width; never narrower than one bit
  function automatic int id_width(input int n_ch);
    return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request at or after ptr, wrapping modulo N_CH. The request
//               vector is doubled so that a single lowest-index scan over the
//               masked upper region handles the wrap without a second pass.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import mutex_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int IDW  = id_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  win_id
);

  logic [2*N_CH-1:0] w_req_dbl;
  logic [2*N_CH-1:0] w_masked;
  logic [IDW-1:0]    w_win_id;

  assign w_req_dbl = {req, req};

  // Suppress positions below ptr; the upper copy still holds every request
  always_comb begin
    w_masked = '0;
    for (int j = 0; j < 2 * N_CH; j++) begin
      w_masked[j] = w_req_dbl[j] & (j >= int'(ptr));
    end
  end

  // Lowest set position wins; scanning downwards lets the last hit stand
  always_comb begin
    w_win_id = '0;
    for (int j = 2 * N_CH - 1; j >= 0; j--) begin
      if (w_masked[j]) begin
        w_win_id = (j >= N_CH) ? IDW'(j - N_CH) : IDW'(j);
      end
    end
  end

  assign any    = |req;
  assign win_id = w_win_id;

endmodule
`default_nettype wire

// File: rtl/mutex_rr.sv
`default_nettype none
// ============================================================================
// Module      : mutex_rr
// Description : N-channel mutual-exclusion element with a four-phase
//               request/grant handshake and round-robin fairness. At most one
//               channel owns the resource; ownership ends when the owner
//               drops its request, after which at least one free cycle
//               precedes the next grant.
//               Build option MUTEX_SYNC_REQ_EN: each request bit passes a
//               two-flop synchroniser first (grant/release latency 3 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module mutex_rr
  import mutex_pkg::*;
#(
  parameter int N_CH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH-1:0]           req,
  output logic [N_CH-1:0]           gnt,
  output logic [id_width(N_CH)-1:0] gnt_id,
  output logic                      busy
);

  localparam int IDW = id_width(N_CH);

  logic [N_CH-1:0] w_req_arb;
  logic            w_any;
  logic [IDW-1:0]  w_win_id;
  logic [N_CH-1:0] w_win_onehot;
  logic [IDW-1:0]  w_next_ptr;
  logic            w_owner_req;

  state_t          r_state;
  logic [N_CH-1:0] r_gnt;
  logic [IDW-1:0]  r_gnt_id;
  logic [IDW-1:0]  r_ptr;
  logic            r_busy;

`ifdef MUTEX_SYNC_REQ_EN
  for (genvar i = 0; i < N_CH; i++) begin : g_req_sync
    logic r_meta;
    logic r_sync;

    // Two-flop synchroniser for a request from an unrelated clock domain
    always_ff @(posedge clk) begin
      if (reset) begin
        r_meta <= 1'b0;
        r_sync <= 1'b0;
      end else begin
        r_meta <= req[i];
        r_sync <= r_meta;
      end
    end

    assign w_req_arb[i] = r_sync;
  end
`else
  assign w_req_arb = req;
`endif

  rr_pick #(
    .N_CH (N_CH),
    .IDW  (IDW)
  ) u_rr_pick (
    .req    (w_req_arb),
    .ptr    (r_ptr),
    .any    (w_any),
    .win_id (w_win_id)
  );

  // Expand the winning index into the one-hot grant pattern
  always_comb begin
    w_win_onehot = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_win_onehot[i] = (w_win_id == IDW'(i));
    end
  end

  // Priority moves to the channel just after the releasing owner
  assign w_next_ptr  = (r_gnt_id == IDW'(N_CH - 1)) ? '0 : r_gnt_id + IDW'(1);
  assign w_owner_req = w_req_arb[r_gnt_id];

  // Ownership FSM with registered grant, owner index, busy and pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
      r_ptr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state  <= ST_OWN;
            r_gnt    <= w_win_onehot;
            r_gnt_id <= w_win_id;
            r_busy   <= 1'b1;
          end
        end
        ST_OWN: begin
          // Other requests stay pending until the owner lets go
          if (!w_owner_req) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mutex_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mutex_rr
// Description : Self-checking bench for mutex_rr with N_CH=4. Table-driven
//               vectors, hand-written corner sequences and random stimulus
//               against a behavioural ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mutex_rr;

  localparam int N = 4;
`ifdef MUTEX_SYNC_REQ_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mutex_rr #(.N_CH(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  // Behavioural model: who owns the resource and where the scan starts
  bit           m_busy;
  int           m_owner;
  int           m_ptr;
  logic [N-1:0] m_d1, m_d2;   // request history, used only with the synchroniser

  task automatic model_step(input logic r, input logic [N-1:0] rq);
    logic [N-1:0] eff;
    bit found;
    if (r) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_d1 = '0; m_d2 = '0;
    end else begin
      eff = SYNC ? m_d2 : rq;
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && eff[(m_ptr + k) % N]) begin
            found = 1; m_owner = (m_ptr + k) % N; m_busy = 1;
          end
        end
      end else if (!eff[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
      m_d2 = m_d1;
      m_d1 = rq;
    end
  endtask

  function automatic int model_gnt();
    return m_busy ? (1 << m_owner) : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 time unit later
  task automatic cycle(input logic r, input logic [N-1:0] rq);
    reset = r;
    req   = rq;
    @(posedge clk);
    model_step(r, rq);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_gnt"}, int'(gnt), model_gnt());
    check({tag, "_id"}, int'(gnt_id), m_owner);
    check({tag, "_busy"}, int'(busy), int'(m_busy));
  endtask

  // Structural invariant on every cycle
  always @(negedge clk) begin
    n_checks++;
    assert ($onehot0(gnt) && (busy == |gnt))
    else begin
      n_errors++;
      $display("FAIL invariant: gnt=%b busy=%b at %0t", gnt, busy, $time);
    end
  end

  typedef struct packed {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   id;
    logic         busy;
  } vec_t;

  vec_t tbl[17];
  int   order[5];
  logic [N-1:0] rq;

  initial begin
    reset = 1'b1;
    req   = '0;

    // {reset, req, expected gnt, expected gnt_id, expected busy} after the edge
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[3]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};  // ptr -> 3
    tbl[5]  = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};  // wrap 3 -> 0
    tbl[6]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1};  // ch1 withdraws
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};  // ptr -> 1
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};  // no grant to ch1
    tbl[9]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 4'b1000, 4'b0000, 2'd1, 1'b0};  // owner pulse, ptr -> 2
    tbl[11] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[12] = '{1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0};  // reset during ownership
    tbl[13] = '{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1};  // ptr was cleared to 0
    tbl[14] = '{1'b0, 4'b0100, 4'b0000, 2'd1, 1'b0};
    tbl[15] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};

    // Reset, then idle for ten cycles
    cycle(1'b1, '0);
    cycle(1'b1, '0);
    compare_model("reset");
    check("reset_gnt_const", int'(gnt), 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0);
      check("idle_gnt", int'(gnt), 0);
      check("idle_busy", int'(busy), 0);
    end

    if (!SYNC) begin
      for (int i = 0; i < 17; i++) begin
        cycle(tbl[i].rst, tbl[i].req);
        check($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
        check($sformatf("tbl%0d_id", i), int'(gnt_id), int'(tbl[i].id));
        check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      end

      // All channels requesting: grants rotate with a free cycle between them
      order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
      cycle(1'b1, '0);
      for (int i = 0; i < 5; i++) begin
        cycle(1'b0, 4'hF);
        check($sformatf("tie%0d_grant", i), int'(gnt), 1 << order[i]);
        cycle(1'b0, 4'hF);
        check($sformatf("tie%0d_hold", i), int'(gnt), 1 << order[i]);
        rq = 4'hF & ~(4'b0001 << order[i]);
        cycle(1'b0, rq);
        check($sformatf("tie%0d_gap", i), int'(gnt), 0);
      end
    end else begin
      // Three-cycle grant and release latency through the synchroniser
      cycle(1'b1, '0);
      cycle(1'b0, 4'b0001);
      check("sync_rise1", int'(gnt), 0);
      cycle(1'b0, 4'b0001);
      check("sync_rise2", int'(gnt), 0);
      cycle(1'b0, 4'b0001);
      check("sync_rise3", int'(gnt), 1);
      cycle(1'b0, 4'b0000);
      check("sync_fall1", int'(gnt), 1);
      cycle(1'b0, 4'b0000);
      check("sync_fall2", int'(gnt), 1);
      cycle(1'b0, 4'b0000);
      check("sync_fall3", int'(gnt), 0);
    end

    // Random stress against the model
    cycle(1'b1, '0);
    rq = '0;
    for (int i = 0; i < 1500; i++) begin
      rq = rq ^ N'($urandom & $urandom);
      cycle(($urandom_range(0, 199) == 0), rq);
      compare_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mutex_rr.md
Name: mutex_rr

Overview:
- Synchronous N-channel mutual-exclusion element, successor to the two-input behavioural mutex.
- Grants exclusive ownership of one shared resource to at most one of N_CH requesters.
- Uses a four-phase request/grant handshake and round-robin fairness; the behavioural block used random tie-breaking.
- Sits between LDL-style request sources (GPIO/Wishbone-side agents) and a shared register or bus port. Fully synthesizable; no delays or $random.

Parameters:
- N_CH, 2, number of requester channels (legal 2..16).
- IDW, derived localparam = max(1, clog2(N_CH)), width of gnt_id.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous active-high reset
- req  input  N_CH  request per channel; held high until grant seen, then held while owning
- gnt  output  N_CH  one-hot grant (all-zero when free)
- gnt_id  output  IDW  index of current owner; valid only when busy=1
- busy  output  1  resource owned (OR of gnt)

Behaviour:
- Reset (synchronous, sampled on clk edge with reset=1):
  - gnt=0, gnt_id=0, busy=0, state=IDLE, rr pointer ptr=0.
  - Reset overrides any ongoing ownership. Grant drops the cycle after reset is sampled, regardless of req.
- States: IDLE, OWN. All outputs are registered.
- IDLE:
  - If req!=0 at edge t, pick the winner w = first index i with req[i]=1, scanning ptr, ptr+1, ... wrapping mod N_CH.
  - At edge t: gnt[w]=1, gnt_id=w, busy=1, state=OWN. Grant is visible in the cycle after req is sampled; latency is 1 cycle.
  - If req==0, stay in IDLE.
- OWN:
  - While req[gnt_id]=1, hold gnt unchanged. Other requests are ignored and stay pending.
  - When req[gnt_id]=0 is sampled at edge t: gnt=0, busy=0, ptr=(gnt_id+1) mod N_CH with wrap from N_CH-1 to 0, state=IDLE.
  - gnt_id keeps its last value while busy=0.
- Release gap: after a release there is at least one cycle with gnt=0 before the next grant. Earliest re-grant is at release edge + 1.
- Simultaneous requests: no randomness. The round-robin order from ptr decides.
  - Example, N_CH=4: ptr=0 and req=4'b1010 grants channel 1.
- Withdrawal: a non-owner dropping req before being granted is simply withdrawn; no grant is issued to it.
- Owner pulse: if the owner drops req in the same cycle the grant appears, release follows the normal rule on the next edge, so the grant lasts 1 cycle.
- No starvation: with all channels continuously re-requesting, each channel is granted once every N_CH grants.
- Invariant: $onehot0(gnt) on every cycle; busy == |gnt.

Optional Feature:
- MUTEX_SYNC_REQ_EN defined:
  - Each req bit passes through a 2-flop synchroniser, reset to 0, before the arbiter. Supports req sourced from an asynchronous LDL domain.
  - Grant latency becomes 3 cycles from req rise.
  - Release latency becomes 3 cycles from req fall.
  - The synchroniser flops are cleared by reset.
- Not defined: req is used directly. Latency is 1 cycle for grant and 1 cycle for release.

Decomposition:
- Package mutex_pkg: state encoding constants (ST_IDLE=1'b0, ST_OWN=1'b1) and a clog2 constant function used to derive IDW.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N_CH], ptr[IDW].
  - Outputs: any, win_id[IDW].
  - Uses the double-width masked priority encode.
- Top module: state register, ptr, output registers, and the optional synchroniser generate block.

Test Plan (N_CH=4, macro undefined unless stated):
- Reset, then idle: req=0 for 10 cycles -> gnt=0, busy=0 throughout. Reset asserted during OWN of ch2 -> gnt=0 on next edge, ptr back to 0.
- Single request: req=4'b0100 at edge t -> gnt=4'b0100, gnt_id=2 at t+1. Drop req at t+5 -> gnt=0 at t+6, ptr=3.
- Tie: ptr=0, req=4'b1111 held, each owner releases 2 cycles after its grant -> grant order 0,1,2,3,0, with one gnt=0 cycle between each grant.
- Wrap and withdrawal: ptr=3, req=4'b0011 -> ch0 granted. Ch1 withdraws while ch0 owns -> after ch0 releases, state returns to IDLE and no grant is issued.
- Owner pulse: req[1] high for exactly the sampling cycle -> gnt[1] high 1 cycle, then released; assert $onehot0(gnt) on every cycle of random stress.
- MUTEX_SYNC_REQ_EN defined: req[0] rises at edge t -> gnt[0] at t+3. req[0] falls at edge u -> gnt[0] low at u+3.
